// File: rtl/apb4_reg_bridge_if.sv
// APB4 completer port and register-bus requester port of apb4_reg_bridge.
// The slave modport is the bridge's view; master is the view of everything around it.
interface apb4_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  logic                    bus_req;
  logic                    bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wr_data;
  logic [DATA_WIDTH-1:0]   bus_wr_biten;
  logic                    bus_req_stall_wr;
  logic                    bus_req_stall_rd;
  logic                    bus_rd_ack;
  logic [DATA_WIDTH-1:0]   bus_rd_data;
  logic                    bus_rd_err;
  logic                    bus_wr_ack;
  logic                    bus_wr_err;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr,
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_req_stall_wr, bus_req_stall_rd,
    input  bus_rd_ack, bus_rd_data, bus_rd_err, bus_wr_ack, bus_wr_err
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr,
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_req_stall_wr, bus_req_stall_rd,
    output bus_rd_ack, bus_rd_data, bus_rd_err, bus_wr_ack, bus_wr_err
  );
endinterface

// File: rtl/apb4_reg_bridge.sv
// APB4 completer turning each transfer into one register-bus request with registered response.
// Define APB_BRIDGE_TIMEOUT_EN to add the WAIT-state ack timeout and late-ack drain.
module apb4_reg_bridge #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          PRIV_ONLY      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              clk,
  input logic              rst_n,
  apb4_reg_bridge_if.slave ifc
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb   = $clog2(StrbWidth);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = {ADDR_WIDTH{1'b1}} << AddrLsb;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic                   pready_q, pready_d;
  logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;

  logic                   req;
  logic                   stall_sel;
  logic                   ack_sel;
  logic                   err_sel;
  logic                   drain_blk;
  logic                   timeout;
  logic [DATA_WIDTH-1:0]  biten;

  // Only the channel matching the captured direction matters; the other is ignored.
  assign stall_sel = wr_q ? ifc.bus_req_stall_wr : ifc.bus_req_stall_rd;
  assign ack_sel   = wr_q ? ifc.bus_wr_ack       : ifc.bus_rd_ack;
  assign err_sel   = wr_q ? ifc.bus_wr_err       : ifc.bus_rd_err;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                drain_wr_q, drain_wr_d;
  logic                drain_ack;

  assign drain_ack = drain_wr_q ? ifc.bus_wr_ack : ifc.bus_rd_ack;
  assign drain_blk = drain_q;
  assign timeout   = (state_q == StWait) && !ack_sel &&
                     (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

  // The abandoned request's late ack is swallowed wherever the FSM happens to be.
  always_comb begin
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    drain_wr_d = drain_wr_q;
    if (drain_q && drain_ack) begin
      drain_d = 1'b0;
    end
    if (state_q == StReq) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
    if (timeout) begin
      drain_d    = 1'b1;
      drain_wr_d = wr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      drain_wr_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      drain_wr_q <= drain_wr_d;
    end
  end
`else
  assign drain_blk = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    req       = 1'b0;

    unique case (state_q)
      StIdle: begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (ifc.psel && !ifc.penable) begin
          addr_d  = ifc.paddr;
          wr_d    = ifc.pwrite;
          wdata_d = ifc.pwdata;
          strb_d  = ifc.pstrb;
          if (PRIV_ONLY && !ifc.pprot[0]) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (ifc.pwrite && (ifc.pstrb == '0)) begin
            state_d  = StResp;
            pready_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end

      StReq: begin
        if (!ifc.psel) begin
          state_d = StIdle;
        end else if (!stall_sel && !drain_blk) begin
          req = 1'b1;
          if (ack_sel) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            prdata_d  = wr_q ? '0 : ifc.bus_rd_data;
            pslverr_d = err_sel;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        // An abandoned transfer still owns the bus until its ack or timeout.
        if (ack_sel || timeout) begin
          if (ifc.psel) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            prdata_d  = (wr_q || timeout) ? '0 : ifc.bus_rd_data;
            pslverr_d = timeout ? 1'b1 : err_sel;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StResp: begin
        state_d   = StIdle;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    biten = '0;
    for (int k = 0; k < int'(StrbWidth); k++) begin
      biten[k*8 +: 8] = {8{strb_q[k]}};
    end
  end

  assign ifc.pready        = pready_q;
  assign ifc.prdata        = prdata_q;
  assign ifc.pslverr       = pslverr_q;
  assign ifc.bus_req       = req;
  assign ifc.bus_req_is_wr = req & wr_q;
  assign ifc.bus_addr      = req ? (addr_q & AddrMask) : '0;
  assign ifc.bus_wr_data   = (req && wr_q) ? wdata_q : '0;
  assign ifc.bus_wr_biten  = (req && wr_q) ? biten : '0;

endmodule
